// File: rtl/vga_timing_recover.sv
// Rebuilds col/row/active from a VGA sync/blank stream and measures its timing.
// Asserts locked once LOCK_FRAMES consecutive frames repeat the same measurements.
module vga_timing_recover #(
  parameter int HBITS       = 10,
  parameter int VBITS       = 10,
  parameter bit HSYNC_POL   = 1'b1,
  parameter bit VSYNC_POL   = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             dot_clock,
  input  logic             reset,
  input  logic             hsync,
  input  logic             hblank,
  input  logic             vsync,
  input  logic             vblank,
  output logic [HBITS-1:0] col,
  output logic [VBITS-1:0] row,
  output logic             active,
  output logic             frame_start,
  output logic             locked,
  output logic [HBITS-1:0] h_total,
  output logic [HBITS-1:0] h_active,
  output logic [HBITS-1:0] h_sync,
  output logic [VBITS-1:0] v_total,
  output logic [VBITS-1:0] v_active,
  output logic [VBITS-1:0] v_sync
);

  localparam int SIXW = 3*HBITS + 3*VBITS;
  localparam logic [3:0] LOCK_MAX = 4'(LOCK_FRAMES);

  typedef struct packed {
    logic hs;   // hsync at its asserted level
    logic hb;
    logic vs;   // vsync at its asserted level
    logic vb;
  } sync_t;

  function automatic logic [HBITS-1:0] inc_h(input logic [HBITS-1:0] a, input logic en);
    return (en && (a != '1)) ? a + HBITS'(1) : a;
  endfunction

  function automatic logic [VBITS-1:0] inc_v(input logic [VBITS-1:0] a, input logic en);
    return (en && (a != '1)) ? a + VBITS'(1) : a;
  endfunction

  sync_t s1_reg, s1_next;
  logic  s1d_hb_reg, s1d_vb_reg;

  logic [HBITS-1:0] dot_cnt_reg, dot_cnt_next;
  logic [HBITS-1:0] act_cnt_reg, act_cnt_next;
  logic [HBITS-1:0] hs_cnt_reg, hs_cnt_next;
  logic [VBITS-1:0] line_cnt_reg, line_cnt_next;
  logic [VBITS-1:0] vact_cnt_reg, vact_cnt_next;
  logic [VBITS-1:0] vs_cnt_reg, vs_cnt_next;

  logic             h_seen_reg, h_seen_next;
  logic             v_seen_reg, v_seen_next;
  logic             ref_valid_reg, ref_valid_next;
  logic             frame_bad_reg, frame_bad_next;
  logic             stored_valid_reg, stored_valid_next;
  logic [3*HBITS-1:0] ref_reg, ref_next;
  logic [SIXW-1:0]  stored_reg, stored_next;
  logic [3:0]       match_cnt_reg, match_cnt_next;

  logic [HBITS-1:0] col_reg, col_next;
  logic [VBITS-1:0] row_reg, row_next;
  logic             active_reg, active_next;
  logic             frame_start_reg, frame_start_next;
  logic             locked_reg, locked_next;
  logic [HBITS-1:0] h_total_reg, h_total_next;
  logic [HBITS-1:0] h_active_reg, h_active_next;
  logic [HBITS-1:0] h_sync_reg, h_sync_next;
  logic [VBITS-1:0] v_total_reg, v_total_next;
  logic [VBITS-1:0] v_active_reg, v_active_next;
  logic [VBITS-1:0] v_sync_reg, v_sync_next;

  logic             line_end, frame_end, act_line, timeout;
  logic             h_meas, v_meas, h_mismatch, frame_bad_now;
  logic [3*HBITS-1:0] line_meas;
  logic [VBITS-1:0] fin_lines, fin_vact, fin_vsync;
  logic [SIXW-1:0]  six_new;

  always_comb begin
    s1_next.hs = (hsync == HSYNC_POL);
    s1_next.hb = hblank;
    s1_next.vs = (vsync == VSYNC_POL);
    s1_next.vb = vblank;

    line_end  = s1_reg.hb & ~s1d_hb_reg;
    frame_end = s1_reg.vb & ~s1d_vb_reg;
    // The vblank value before this cycle decides whether the finishing line was active.
    act_line  = line_end & ~s1d_vb_reg;
    timeout   = (~line_end & (dot_cnt_reg == '1)) | (~frame_end & (line_cnt_reg == '1));

    h_meas     = line_end & h_seen_reg;
    v_meas     = frame_end & v_seen_reg;
    line_meas  = {dot_cnt_reg, act_cnt_reg, hs_cnt_reg};
    h_mismatch = h_meas & ref_valid_reg & (line_meas != ref_reg);
    frame_bad_now = frame_bad_reg | h_mismatch;

    // A line end coinciding with the frame end still belongs to the finishing frame.
    fin_lines = inc_v(line_cnt_reg, line_end);
    fin_vact  = inc_v(vact_cnt_reg, act_line);
    fin_vsync = inc_v(vs_cnt_reg, line_end & s1_reg.vs);

    dot_cnt_next  = line_end ? HBITS'(1) : inc_h(dot_cnt_reg, 1'b1);
    act_cnt_next  = line_end ? '0 : inc_h(act_cnt_reg, ~s1_reg.hb);
    hs_cnt_next   = line_end ? HBITS'(s1_reg.hs) : inc_h(hs_cnt_reg, s1_reg.hs);
    line_cnt_next = frame_end ? '0 : inc_v(line_cnt_reg, line_end);
    vact_cnt_next = frame_end ? '0 : inc_v(vact_cnt_reg, act_line);
    vs_cnt_next   = frame_end ? '0 : inc_v(vs_cnt_reg, line_end & s1_reg.vs);

    h_total_next  = h_meas ? dot_cnt_reg : h_total_reg;
    h_active_next = h_meas ? act_cnt_reg : h_active_reg;
    h_sync_next   = h_meas ? hs_cnt_reg  : h_sync_reg;
    v_total_next  = v_meas ? fin_lines : v_total_reg;
    v_active_next = v_meas ? fin_vact  : v_active_reg;
    v_sync_next   = v_meas ? fin_vsync : v_sync_reg;

    h_seen_next    = timeout ? 1'b0 : (line_end ? 1'b1 : h_seen_reg);
    v_seen_next    = timeout ? 1'b0 : (frame_end ? 1'b1 : v_seen_reg);
    ref_next       = (h_meas & ~ref_valid_reg) ? line_meas : ref_reg;
    ref_valid_next = frame_end ? 1'b0 : (h_meas ? 1'b1 : ref_valid_reg);
    frame_bad_next = frame_end ? 1'b0 : frame_bad_now;

    six_new = {h_total_next, h_active_next, h_sync_next, fin_lines, fin_vact, fin_vsync};
    stored_next       = v_meas ? six_new : stored_reg;
    stored_valid_next = timeout ? 1'b0 : (v_meas ? 1'b1 : stored_valid_reg);

    match_cnt_next = match_cnt_reg;
    if (timeout) begin
      match_cnt_next = '0;
    end else if (v_meas) begin
      if (stored_valid_reg && (six_new == stored_reg) && !frame_bad_now)
        match_cnt_next = (match_cnt_reg >= LOCK_MAX) ? LOCK_MAX : match_cnt_reg + 4'd1;
      else
        match_cnt_next = '0;
    end
    locked_next = (match_cnt_next == LOCK_MAX);

    col_next = s1_reg.hb ? col_reg : (s1d_hb_reg ? '0 : inc_h(col_reg, 1'b1));
    row_next = frame_end ? '0 : inc_v(row_reg, act_line);
    active_next      = ~timeout & ~s1_reg.hb & ~s1_reg.vb;
    frame_start_next = frame_end;
  end

  always_ff @(posedge dot_clock) begin
    if (reset) begin
      s1_reg           <= '0;
      s1d_hb_reg       <= 1'b0;
      s1d_vb_reg       <= 1'b0;
      dot_cnt_reg      <= '0;
      act_cnt_reg      <= '0;
      hs_cnt_reg       <= '0;
      line_cnt_reg     <= '0;
      vact_cnt_reg     <= '0;
      vs_cnt_reg       <= '0;
      h_seen_reg       <= 1'b0;
      v_seen_reg       <= 1'b0;
      ref_valid_reg    <= 1'b0;
      frame_bad_reg    <= 1'b0;
      stored_valid_reg <= 1'b0;
      ref_reg          <= '0;
      stored_reg       <= '0;
      match_cnt_reg    <= '0;
      col_reg          <= '0;
      row_reg          <= '0;
      active_reg       <= 1'b0;
      frame_start_reg  <= 1'b0;
      locked_reg       <= 1'b0;
      h_total_reg      <= '0;
      h_active_reg     <= '0;
      h_sync_reg       <= '0;
      v_total_reg      <= '0;
      v_active_reg     <= '0;
      v_sync_reg       <= '0;
    end else begin
      s1_reg           <= s1_next;
      s1d_hb_reg       <= s1_reg.hb;
      s1d_vb_reg       <= s1_reg.vb;
      dot_cnt_reg      <= dot_cnt_next;
      act_cnt_reg      <= act_cnt_next;
      hs_cnt_reg       <= hs_cnt_next;
      line_cnt_reg     <= line_cnt_next;
      vact_cnt_reg     <= vact_cnt_next;
      vs_cnt_reg       <= vs_cnt_next;
      h_seen_reg       <= h_seen_next;
      v_seen_reg       <= v_seen_next;
      ref_valid_reg    <= ref_valid_next;
      frame_bad_reg    <= frame_bad_next;
      stored_valid_reg <= stored_valid_next;
      ref_reg          <= ref_next;
      stored_reg       <= stored_next;
      match_cnt_reg    <= match_cnt_next;
      col_reg          <= col_next;
      row_reg          <= row_next;
      active_reg       <= active_next;
      frame_start_reg  <= frame_start_next;
      locked_reg       <= locked_next;
      h_total_reg      <= h_total_next;
      h_active_reg     <= h_active_next;
      h_sync_reg       <= h_sync_next;
      v_total_reg      <= v_total_next;
      v_active_reg     <= v_active_next;
      v_sync_reg       <= v_sync_next;
    end
  end

  assign col         = col_reg;
  assign row         = row_reg;
  assign active      = active_reg;
  assign frame_start = frame_start_reg;
  assign locked      = locked_reg;
  assign h_total     = h_total_reg;
  assign h_active    = h_active_reg;
  assign h_sync      = h_sync_reg;
  assign v_total     = v_total_reg;
  assign v_active    = v_active_reg;
  assign v_sync      = v_sync_reg;

endmodule

// File: tb/tb_vga_timing_recover.sv
// Directed bench: 20x10 test timing, expected per-dot results queued at drive time.
module tb_vga_timing_recover;

  logic dot_clock = 1'b0;
  logic reset, hsync, hblank, vsync, vblank, hsync_n;
  logic [9:0] col, row, h_total, h_active, h_sync, v_total, v_active, v_sync;
  logic active, frame_start, locked;
  logic [9:0] col2, row2, h_total2, h_active2, h_sync2, v_total2, v_active2, v_sync2;
  logic active2, frame_start2, locked2;

  always #5 dot_clock = ~dot_clock;
  assign hsync_n = ~hsync;

  vga_timing_recover #(.HBITS(10), .VBITS(10), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .LOCK_FRAMES(2)) dut (
    .dot_clock(dot_clock), .reset(reset), .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
    .col(col), .row(row), .active(active), .frame_start(frame_start), .locked(locked),
    .h_total(h_total), .h_active(h_active), .h_sync(h_sync),
    .v_total(v_total), .v_active(v_active), .v_sync(v_sync)
  );

  vga_timing_recover #(.HBITS(10), .VBITS(10), .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .LOCK_FRAMES(2)) dut_npol (
    .dot_clock(dot_clock), .reset(reset), .hsync(hsync_n), .hblank(hblank), .vsync(vsync), .vblank(vblank),
    .col(col2), .row(row2), .active(active2), .frame_start(frame_start2), .locked(locked2),
    .h_total(h_total2), .h_active(h_active2), .h_sync(h_sync2),
    .v_total(v_total2), .v_active(v_active2), .v_sync(v_sync2)
  );

  typedef struct {
    int         due;
    bit         chk_col;
    logic [9:0] col, row;
    logic       active, fs, lock;
    logic [9:0] ht, ha, hs, vt, va, vs;
  } exp_t;

  exp_t q[$];
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  // Stream model state
  int         prev_len = 20;
  bit         line_open = 0;
  bit         frame_open = 0;
  logic       lock_lvl = 1'b0;
  logic [9:0] ht_e = '0, ha_e = '0, hs_e = '0, vt_e = '0, va_e = '0, vs_e = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_rec(input exp_t e);
    if (e.chk_col) chk("col", 32'(col), 32'(e.col));
    chk("row", 32'(row), 32'(e.row));
    chk("active", 32'(active), 32'(e.active));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
    chk("locked", 32'(locked), 32'(e.lock));
    chk("h_total", 32'(h_total), 32'(e.ht));
    chk("h_active", 32'(h_active), 32'(e.ha));
    chk("h_sync", 32'(h_sync), 32'(e.hs));
    chk("v_total", 32'(v_total), 32'(e.vt));
    chk("v_active", 32'(v_active), 32'(e.va));
    chk("v_sync", 32'(v_sync), 32'(e.vs));
    chk("npol_h_sync", 32'(h_sync2), 32'(e.hs));
    chk("npol_locked", 32'(locked2), 32'(e.lock));
  endtask

  task automatic tick();
    exp_t e;
    @(posedge dot_clock);
    cyc++;
    @(negedge dot_clock);
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check_rec(e);
    end
  endtask

  task automatic check_zero(input string ph);
    chk({ph, "_col"}, 32'(col), 0);
    chk({ph, "_row"}, 32'(row), 0);
    chk({ph, "_active"}, 32'(active), 0);
    chk({ph, "_frame_start"}, 32'(frame_start), 0);
    chk({ph, "_locked"}, 32'(locked), 0);
    chk({ph, "_h_total"}, 32'(h_total), 0);
    chk({ph, "_h_active"}, 32'(h_active), 0);
    chk({ph, "_h_sync"}, 32'(h_sync), 0);
    chk({ph, "_v_total"}, 32'(v_total), 0);
    chk({ph, "_v_active"}, 32'(v_active), 0);
    chk({ph, "_v_sync"}, 32'(v_sync), 0);
    chk({ph, "_npol_locked"}, 32'(locked2), 0);
  endtask

  task automatic model_reset();
    line_open = 0; frame_open = 0; lock_lvl = 1'b0;
    ht_e = '0; ha_e = '0; hs_e = '0; vt_e = '0; va_e = '0; vs_e = '0;
  endtask

  // Lines 0..3 vblank (vsync on 1..2); dots: blank first, hsync on dots 2..4, last 12 active.
  task automatic run_frame(input int bad_line, input logic lock_exp, input int nlines);
    for (int ln = 0; ln < nlines; ln++) begin
      int len;
      len = (ln == bad_line) ? 21 : 20;
      for (int d = 0; d < len; d++) begin
        exp_t e;
        hblank = (d < len - 12);
        hsync  = (d >= 2 && d <= 4);
        vblank = (ln < 4);
        vsync  = (ln == 1 || ln == 2);
        if (d == 0) begin
          if (line_open) begin
            ht_e = 10'(prev_len); ha_e = 10'd12; hs_e = 10'd3;
          end
          line_open = 1;
          prev_len = len;
          if (ln == 0) begin
            if (frame_open) begin
              vt_e = 10'd10; va_e = 10'd6; vs_e = 10'd2;
            end
            frame_open = 1;
            lock_lvl = lock_exp;
          end
        end
        e.due     = cyc + 2;
        e.chk_col = !hblank;
        e.col     = 10'(d - (len - 12));
        e.row     = (ln >= 5) ? 10'(ln - 4) : 10'd0;
        e.active  = !hblank && !vblank;
        e.fs      = (ln == 0 && d == 0);
        e.lock    = lock_lvl;
        e.ht = ht_e; e.ha = ha_e; e.hs = hs_e;
        e.vt = vt_e; e.va = va_e; e.vs = vs_e;
        q.push_back(e);
        tick();
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hsync = 1'b0; hblank = 1'b0; vsync = 1'b0; vblank = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    check_zero("reset");
    reset = 1'b0;

    // Acquire lock, then one frame with a 21-dot line
    run_frame(-1, 1'b0, 10);
    run_frame(-1, 1'b0, 10);
    run_frame(-1, 1'b0, 10);
    run_frame(-1, 1'b1, 10);
    run_frame(5, 1'b1, 10);
    run_frame(-1, 1'b0, 10);
    run_frame(-1, 1'b0, 10);
    run_frame(-1, 1'b1, 10);

    // hblank stuck low: dot counter runs into saturation
    hblank = 1'b0; hsync = 1'b0; vblank = 1'b0; vsync = 1'b0;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (i == 900) begin
        chk("pre_timeout_locked", 32'(locked), 1);
        chk("pre_timeout_active", 32'(active), 1);
      end
    end
    chk("timeout_locked", 32'(locked), 0);
    chk("timeout_active", 32'(active), 0);
    chk("timeout_col_sat", 32'(col), 1023);
    chk("timeout_h_total_hold", 32'(h_total), 20);
    chk("timeout_v_total_hold", 32'(v_total), 10);
    chk("timeout_npol_locked", 32'(locked2), 0);
    line_open = 0; frame_open = 0; lock_lvl = 1'b0;

    run_frame(-1, 1'b0, 10);
    run_frame(-1, 1'b0, 10);
    run_frame(-1, 1'b0, 10);
    run_frame(-1, 1'b1, 10);

    // Reset in the middle of a locked frame
    run_frame(-1, 1'b1, 7);
    q.delete();
    reset = 1'b1;
    tick();
    check_zero("midreset");
    reset = 1'b0;
    model_reset();

    run_frame(-1, 1'b0, 10);
    run_frame(-1, 1'b0, 10);
    run_frame(-1, 1'b0, 10);
    run_frame(-1, 1'b1, 10);
    run_frame(-1, 1'b1, 10);
    for (int i = 0; i < 3; i++) tick();
    chk("queue_drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
